// File: rtl/bft_pkg.sv
// Shared BFT packet definitions: field positions, packet struct and builder.
package bft_pkg;

    localparam int VALID_BIT = 48;
    localparam int LEAF_MSB  = 47;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_MSB  = 42;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_MSB  = 38;
    localparam int ADDR_LSB  = 32;

    typedef struct packed {
        logic        valid;
        logic [4:0]  leaf;
        logic [3:0]  port;
        logic [6:0]  addr;
        logic [31:0] payload;
    } bft_packet_t;

    function automatic bft_packet_t mk_packet(input logic [4:0]  leaf,
                                              input logic [3:0]  port,
                                              input logic [6:0]  addr,
                                              input logic [31:0] payload);
        bft_packet_t p;
        p.valid   = 1'b1;
        p.leaf    = leaf;
        p.port    = port;
        p.addr    = addr;
        p.payload = payload;
        return p;
    endfunction

endpackage

// File: rtl/leaf_rx_port_if.sv
// Payload stream toward the user kernel (vld/ack handshake).
interface leaf_rx_port_if
    import bft_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
    logic                    vld_interface2user;
    logic                    ack_user2interface;

    modport master (
        output dout_leaf_interface2user,
        output vld_interface2user,
        input  ack_user2interface
    );

    modport slave (
        input  dout_leaf_interface2user,
        input  vld_interface2user,
        output ack_user2interface
    );
endinterface

// File: rtl/leaf_rx_fifo.sv
// First-word-fall-through circular FIFO; a pop frees a slot for a same-cycle push.
module leaf_rx_fifo #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr;
    logic [ADDR_BITS:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                     (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[ADDR_BITS-1:0]];

    // Pointer update; both pointers may advance in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_BITS-1:0]] <= din;
    end
endmodule

// File: rtl/leaf_rx_port.sv
// BFT leaf receive port: address filter, payload FIFO, drop/overflow status, credit return.
module leaf_rx_port
    import bft_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int LEAF_ID               = 2,
    parameter int PORT_ID               = 1,
    parameter int SRC_LEAF              = 0,
    parameter int SRC_PORT              = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKET_BITS-1:0] din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0] dout_credit,
    input  logic                   resend,
    leaf_rx_port_if.master         user,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);
    localparam int PORT_LSB_P = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int LEAF_LSB_P = PORT_LSB_P + NUM_PORT_BITS;
    localparam int UPD_BITS   = $clog2(FREESPACE_UPDATE_SIZE);

    logic                     r_valid;
    logic [NUM_LEAF_BITS-1:0] r_leaf;
    logic [NUM_PORT_BITS-1:0] r_port;
    logic [PAYLOAD_BITS-1:0]  r_payload;

    logic hit;
    logic miss;
    logic pop;
    logic full;
    logic empty;
    logic [31:0]            consumed;
    logic [31:0]            consumed_nxt;
    logic                   credit_due;
    logic [PACKET_BITS-1:0] credit_pkt;
    logic [PACKET_BITS-1:0] last_credit;

    // Input register stage; the address field is not needed and not kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_leaf    <= '0;
            r_port    <= '0;
            r_payload <= '0;
        end else begin
            r_valid   <= din_leaf_bft2interface[PACKET_BITS-1];
            r_leaf    <= din_leaf_bft2interface[LEAF_LSB_P +: NUM_LEAF_BITS];
            r_port    <= din_leaf_bft2interface[PORT_LSB_P +: NUM_PORT_BITS];
            r_payload <= din_leaf_bft2interface[PAYLOAD_BITS-1:0];
        end
    end

    assign hit  = r_valid && (r_leaf == NUM_LEAF_BITS'(LEAF_ID)) &&
                  (r_port == NUM_PORT_BITS'(PORT_ID));
    assign miss = r_valid && !hit;
    assign pop  = user.ack_user2interface && !empty;

    leaf_rx_fifo #(
        .WIDTH     (PAYLOAD_BITS),
        .ADDR_BITS (NUM_BRAM_ADDR_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (hit),
        .din   (r_payload),
        .pop   (pop),
        .dout  (user.dout_leaf_interface2user),
        .full  (full),
        .empty (empty)
    );

    assign user.vld_interface2user = !empty;

    // Sticky overflow and saturating misaddress counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (hit && full && !pop) overflow <= 1'b1;
            if (miss && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign consumed_nxt = consumed + 32'd1;
    assign credit_due   = pop && (consumed_nxt[UPD_BITS-1:0] == '0);
    assign credit_pkt   = {1'b1, NUM_LEAF_BITS'(SRC_LEAF), NUM_PORT_BITS'(SRC_PORT),
                           {NUM_ADDR_BITS{1'b0}}, PAYLOAD_BITS'(consumed_nxt)};

    // Consumption counter and credit emission; a due credit supersedes a resend.
    always_ff @(posedge clk) begin
        if (reset) begin
            consumed    <= '0;
            last_credit <= '0;
            dout_credit <= '0;
        end else begin
            if (pop) consumed <= consumed_nxt;
            if (credit_due) begin
                dout_credit <= credit_pkt;
                last_credit <= credit_pkt;
            end else if (resend) begin
                dout_credit <= last_credit;
            end else begin
                dout_credit <= '0;
            end
        end
    end
endmodule

// File: tb/tb_leaf_rx_port.sv
// Self-checking bench for leaf_rx_port: cycle model scoreboard plus directed checks.
module tb_leaf_rx_port;
    import bft_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [48:0] din = '0;
    logic [48:0] dout_credit;
    logic        resend = 1'b0;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    leaf_rx_port_if #(.PAYLOAD_BITS(32)) u_if ();

    leaf_rx_port #(
        .LEAF_ID  (2),
        .PORT_ID  (1),
        .SRC_LEAF (0),
        .SRC_PORT (1)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .din_leaf_bft2interface (din),
        .dout_credit            (dout_credit),
        .resend                 (resend),
        .user                   (u_if),
        .overflow               (overflow),
        .drop_cnt               (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state; expected payloads are queued when accepted.
    logic [31:0] mq[$];
    logic [31:0] pop_log[$];
    logic [48:0] cred_log[$];
    logic        m_rv = 1'b0;
    logic [4:0]  m_rl = '0;
    logic [3:0]  m_rp = '0;
    logic [31:0] m_rpay = '0;
    logic        m_ovf = 1'b0;
    int          m_drop = 0;
    logic [31:0] m_cons = '0;
    logic [48:0] m_cred = '0;
    logic [48:0] m_last = '0;
    bit          m_init = 1'b0;

    // Compare DUT against the model mid-cycle, then advance the model over the next edge.
    always @(negedge clk) begin
        logic        m_pop;
        logic        m_full;
        logic        m_hit;
        logic [31:0] cons_n;
        if (m_init) begin
            check("vld", {63'd0, u_if.vld_interface2user}, {63'd0, mq.size() != 0});
            if (mq.size() != 0) check("dout", {32'd0, u_if.dout_leaf_interface2user}, {32'd0, mq[0]});
            check("credit", {15'd0, dout_credit}, {15'd0, m_cred});
            check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
            check("drop_cnt", {48'd0, drop_cnt}, 64'(m_drop));
        end
        if (!reset && u_if.vld_interface2user && u_if.ack_user2interface)
            pop_log.push_back(u_if.dout_leaf_interface2user);
        if (!reset && dout_credit[48]) cred_log.push_back(dout_credit);

        if (reset) begin
            mq.delete();
            m_rv = 1'b0; m_ovf = 1'b0; m_drop = 0; m_cons = '0;
            m_cred = '0; m_last = '0;
            m_init = 1'b1;
        end else begin
            m_pop  = u_if.ack_user2interface && (mq.size() > 0);
            m_full = (mq.size() == 128);
            m_hit  = m_rv && (m_rl == 5'd2) && (m_rp == 4'd1);
            cons_n = m_cons + (m_pop ? 32'd1 : 32'd0);
            if (m_pop) void'(mq.pop_front());
            if (m_hit) begin
                if (!m_full || m_pop) mq.push_back(m_rpay);
                else m_ovf = 1'b1;
            end
            if (m_rv && !m_hit && m_drop < 65535) m_drop++;
            if (m_pop && cons_n[5:0] == 6'd0) begin
                m_cred = mk_packet(5'd0, 4'd1, 7'd0, cons_n);
                m_last = m_cred;
            end else if (resend) begin
                m_cred = m_last;
            end else begin
                m_cred = '0;
            end
            m_cons = cons_n;
            m_rv   = din[48];
            m_rl   = din[47:43];
            m_rp   = din[42:39];
            m_rpay = din[31:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        din = '0;
        resend = 1'b0;
        u_if.ack_user2interface = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            din = mk_packet(5'd2, 4'd1, 7'd0, 32'(i));
            tick();
        end
        din = '0;
        repeat (4) tick();
    endtask

    initial begin
        u_if.ack_user2interface = 1'b0;
        tick();
        do_reset();

        // Reset state
        check("rst_vld", {63'd0, u_if.vld_interface2user}, 64'd0);
        check("rst_dout", {32'd0, u_if.dout_leaf_interface2user}, 64'd0);
        check("rst_credit", {15'd0, dout_credit}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_drop", {48'd0, drop_cnt}, 64'd0);

        // In-order delivery and two-cycle latency
        pop_log.delete();
        u_if.ack_user2interface = 1'b1;
        din = mk_packet(5'd2, 4'd1, 7'h15, 32'hA0);
        tick();
        check("lat_vld_t1", {63'd0, u_if.vld_interface2user}, 64'd0);
        din = mk_packet(5'd2, 4'd1, 7'h15, 32'hA1);
        tick();
        check("lat_vld_t2", {63'd0, u_if.vld_interface2user}, 64'd1);
        check("lat_dout_t2", {32'd0, u_if.dout_leaf_interface2user}, 64'hA0);
        din = mk_packet(5'd2, 4'd1, 7'h15, 32'hA2);
        tick();
        din = mk_packet(5'd2, 4'd1, 7'h15, 32'hA3);
        tick();
        din = '0;
        repeat (6) tick();
        check("order_count", 64'(pop_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("order_val", {32'd0, pop_log[i]}, 64'(32'hA0 + i));

        // Misaddressed packets
        do_reset();
        din = mk_packet(5'd3, 4'd1, 7'd0, 32'h11);
        tick();
        din = mk_packet(5'd2, 4'd0, 7'd0, 32'h22);
        tick();
        din = '0;
        repeat (4) tick();
        check("drop_cnt2", {48'd0, drop_cnt}, 64'd2);
        check("drop_vld", {63'd0, u_if.vld_interface2user}, 64'd0);

        // Overflow on the 129th word, then drain
        do_reset();
        fill(129);
        check("ovf_set", {63'd0, overflow}, 64'd1);
        pop_log.delete();
        u_if.ack_user2interface = 1'b1;
        repeat (135) tick();
        u_if.ack_user2interface = 1'b0;
        check("drain_count", 64'(pop_log.size()), 64'd128);
        for (int i = 0; i < 128 && i < pop_log.size(); i++)
            check("drain_val", {32'd0, pop_log[i]}, 64'(i));

        // Push at full with a coincident pop
        do_reset();
        fill(128);
        pop_log.delete();
        din = mk_packet(5'd2, 4'd1, 7'd0, 32'h200);
        tick();
        din = '0;
        u_if.ack_user2interface = 1'b1;
        tick();
        u_if.ack_user2interface = 1'b0;
        repeat (3) tick();
        check("full_pop_ovf", {63'd0, overflow}, 64'd0);
        u_if.ack_user2interface = 1'b1;
        repeat (135) tick();
        u_if.ack_user2interface = 1'b0;
        check("full_pop_count", 64'(pop_log.size()), 64'd129);
        if (pop_log.size() == 129) begin
            check("full_pop_first", {32'd0, pop_log[0]}, 64'd0);
            check("full_pop_last", {32'd0, pop_log[128]}, 64'h200);
        end

        // Credits, resend, and resend coincident with a due credit
        do_reset();
        fill(128);
        cred_log.delete();
        for (int i = 0; i < 128; i++) begin
            u_if.ack_user2interface = 1'b1;
            resend = (i == 80) || (i == 127);
            tick();
        end
        resend = 1'b0;
        repeat (5) tick();
        u_if.ack_user2interface = 1'b0;
        check("credit_count", 64'(cred_log.size()), 64'd3);
        if (cred_log.size() == 3) begin
            check("credit_64", {15'd0, cred_log[0]}, {15'd0, mk_packet(5'd0, 4'd1, 7'd0, 32'd64)});
            check("credit_resend", {15'd0, cred_log[1]}, {15'd0, mk_packet(5'd0, 4'd1, 7'd0, 32'd64)});
            check("credit_128", {15'd0, cred_log[2]}, {15'd0, mk_packet(5'd0, 4'd1, 7'd0, 32'd128)});
        end

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
